// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-oriented UART transceiver.
// UART_PARITY_EN adds the even-parity state to the frame FSMs.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } uart_state_e;

   function automatic int calc_div(input longint clk_hz,
                                   input longint baud);
      return int'(clk_hz / (baud * OVERSAMPLE));
   endfunction

endpackage

// File: rtl/uart_word_xcvr_tick.sv
// Free-running divider producing the shared x16 oversample tick.
// One-cycle pulse every DIV clocks.
module uart_baud_tick #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   if (DIV < 2) begin : g_div_chk
      $error("uart_baud_tick: DIV must be at least 2");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (cnt_q == CW'(DIV - 1)) begin
         cnt_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q + CW'(1);
         tick_q <= 1'b0;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_word_xcvr.sv
// Word-assembling UART transceiver, first byte in the word MSBs.
// Build with UART_PARITY_EN for 8E1 frames; default is 8N1.
module uart_word_xcvr
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 100000000,
   parameter int BAUD         = 115200,
   parameter int WORD_BYTES   = 4,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx,
   output logic                    tx,
   input  logic [8*WORD_BYTES-1:0] tx_word,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic [8*WORD_BYTES-1:0] rx_word,
   output logic                    rx_valid,
   output logic                    rx_frame_err,
   output logic                    rx_parity_err
);

   localparam int W   = 8 * WORD_BYTES;
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(WORD_BYTES + 1);
   localparam int TOT = TIMEOUT_BITS * OVERSAMPLE;
   localparam int TOW = $clog2(TOT + 1);

   if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_wb_chk
      $error("uart_word_xcvr: WORD_BYTES must be 1..8");
   end

   logic tick;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   logic rx_m_q, rx_s_q, rx_p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
         rx_p_q <= 1'b1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
      end
   end

   uart_state_e    rx_st_q;
   logic [3:0]     rx_ph_q;
   logic [2:0]     rx_bit_q;
   logic [7:0]     rx_sh_q;
   logic [W-1:0]   rx_acc_q, rx_word_q;
   logic [CW-1:0]  rx_cnt_q;
   logic [TOW-1:0] rx_to_q;
   logic           rx_vld_q, rx_fe_q, rx_bad;
   logic           rx_fall, rx_mid;

   assign rx_fall = rx_p_q & ~rx_s_q;
   assign rx_mid  = tick && (rx_ph_q == 4'd15);

`ifdef UART_PARITY_EN
   logic rx_par_q, rx_pe_q;
   assign rx_bad        = !rx_s_q || rx_par_q;
   assign rx_parity_err = rx_pe_q;
`else
   assign rx_bad        = !rx_s_q;
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st_q   <= S_IDLE;
         rx_ph_q   <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_acc_q  <= '0;
         rx_cnt_q  <= '0;
         rx_to_q   <= '0;
         rx_word_q <= '0;
         rx_vld_q  <= 1'b0;
         rx_fe_q   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q  <= 1'b0;
         rx_pe_q   <= 1'b0;
`endif
      end else begin
         rx_vld_q <= 1'b0;
         rx_fe_q  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_pe_q  <= 1'b0;
`endif
         if (tick && rx_st_q != S_IDLE) rx_ph_q <= rx_ph_q + 4'd1;
         if (rx_cnt_q == CW'(WORD_BYTES)) begin
            rx_word_q <= rx_acc_q;
            rx_vld_q  <= 1'b1;
            rx_cnt_q  <= '0;
         end
         unique case (rx_st_q)
            S_IDLE: begin
               if (rx_fall) begin
                  rx_st_q <= S_START;
                  rx_ph_q <= '0;
                  rx_to_q <= '0;
               end else if (tick && rx_cnt_q != '0) begin
                  // partial word ages out after TIMEOUT_BITS idle bit-times
                  if (rx_to_q == TOW'(TOT - 1)) begin
                     rx_cnt_q <= '0;
                     rx_to_q  <= '0;
                  end else begin
                     rx_to_q <= rx_to_q + TOW'(1);
                  end
               end
            end
            S_START: begin
               if (tick && rx_ph_q == 4'd7) begin
                  rx_ph_q  <= '0;
                  rx_bit_q <= '0;
                  rx_st_q  <= rx_s_q ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (rx_mid) begin
                  rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
                  rx_bit_q <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                  if (rx_bit_q == 3'd7) rx_st_q <= S_PARITY;
`else
                  if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
`endif
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (rx_mid) begin
                  rx_par_q <= (^rx_sh_q) ^ rx_s_q;
                  rx_st_q  <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (rx_mid) begin
                  rx_fe_q <= !rx_s_q;
`ifdef UART_PARITY_EN
                  rx_pe_q <= rx_par_q;
`endif
                  if (rx_bad) begin
                     rx_cnt_q <= '0;
                  end else begin
                     rx_acc_q <= (rx_acc_q << 8) | W'(rx_sh_q);
                     rx_cnt_q <= rx_cnt_q + CW'(1);
                  end
                  rx_to_q <= '0;
                  rx_st_q <= S_IDLE;
               end
            end
            default: rx_st_q <= S_IDLE;
         endcase
      end
   end

   assign rx_word      = rx_word_q;
   assign rx_valid     = rx_vld_q;
   assign rx_frame_err = rx_fe_q;

   uart_state_e   tx_st_q;
   logic [3:0]    tx_ph_q;
   logic [2:0]    tx_bit_q;
   logic [W-1:0]  tx_w_q;
   logic [CW-1:0] tx_n_q;
   logic          tx_q, tx_rdy_q, tx_go_q;
   logic [7:0]    tx_cur;
   logic          tx_end;

   assign tx_cur = tx_w_q[W-1 -: 8];
   assign tx_end = tick && !tx_go_q && (tx_ph_q == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q  <= S_IDLE;
         tx_ph_q  <= '0;
         tx_bit_q <= '0;
         tx_w_q   <= '0;
         tx_n_q   <= '0;
         tx_q     <= 1'b1;
         tx_rdy_q <= 1'b1;
         tx_go_q  <= 1'b0;
      end else begin
         if (tick && !tx_go_q && tx_st_q != S_IDLE)
            tx_ph_q <= tx_ph_q + 4'd1;
         unique case (tx_st_q)
            S_IDLE: begin
               if (tx_valid && tx_rdy_q) begin
                  tx_w_q   <= tx_word;
                  tx_n_q   <= '0;
                  tx_ph_q  <= '0;
                  tx_go_q  <= 1'b1;
                  tx_rdy_q <= 1'b0;
                  tx_st_q  <= S_START;
               end
            end
            S_START: begin
               // first tick after acceptance opens the start bit
               if (tick && tx_go_q) begin
                  tx_go_q <= 1'b0;
                  tx_q    <= 1'b0;
               end else if (tx_end) begin
                  tx_q     <= tx_cur[0];
                  tx_bit_q <= '0;
                  tx_st_q  <= S_DATA;
               end
            end
            S_DATA: begin
               if (tx_end) begin
                  if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx_q    <= ^tx_cur;
                     tx_st_q <= S_PARITY;
`else
                     tx_q    <= 1'b1;
                     tx_st_q <= S_STOP;
`endif
                  end else begin
                     tx_q     <= tx_cur[tx_bit_q + 3'd1];
                     tx_bit_q <= tx_bit_q + 3'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (tx_end) begin
                  tx_q    <= 1'b1;
                  tx_st_q <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (tx_end) begin
                  if (tx_n_q == CW'(WORD_BYTES - 1)) begin
                     tx_rdy_q <= 1'b1;
                     tx_st_q  <= S_IDLE;
                  end else begin
                     tx_w_q  <= tx_w_q << 8;
                     tx_n_q  <= tx_n_q + CW'(1);
                     tx_q    <= 1'b0;
                     tx_st_q <= S_START;
                  end
               end
            end
            default: tx_st_q <= S_IDLE;
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_ready = tx_rdy_q;

endmodule
